btn_cmd_ctrl: RTL and testbench
===============================

Name: btn_cmd_ctrl

Overview:
Front-end stage that feeds led_handler with its cmd[1:0] and btns[8:0] inputs. It synchronises and debounces the nine raw board buttons and latches a 2-bit LED command from presses on buttons 0..3. Commands are held between presses, and a one-cycle strobe marks each command update.

Parameters:
- CLK_HZ, 12000000, hwclk frequency in Hz; sets the 1 kHz tick prescaler (CLK_HZ/1000 cycles per tick).
- DEBOUNCE_MS, 10, consecutive ticks of stable disagreement required before the debounced level flips (>=1).
- BTN_ACTIVE_LOW, 1, 1 = raw buttons read 0 when pressed; the input is inverted after the synchroniser.

Ports:
- hwclk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btns_raw  in  9  raw asynchronous button pins.
- btns  out  9  debounced button levels, 1 = pressed.
- cmd  out  2  held LED command for led_handler.
- cmd_valid  out  1  one-cycle strobe on the cycle cmd is (re)written.
- cmd_locked  out  1  lock status; tied 0 when CMD_LOCK_EN is undefined.

Behaviour:
- Reset (async assert, sync release): btns=0, cmd=2'b00 (OFF), cmd_valid=0, cmd_locked=0. Sync flops are cleared to the released level, and the prescaler and all debounce counters are cleared.
- Synchroniser: 2-FF per bit, then polarity fix, giving sync[i].
- Prescaler: counts 0..CLK_HZ/1000-1. tick=1 for one cycle at terminal count, then wraps to 0.
- Per-button debounce, independent for each button:
  - Any cycle with sync==stable: counter cleared.
  - Tick cycle with sync!=stable: counter+1.
  - When counter reaches DEBOUNCE_MS: stable<=sync and counter cleared in the same cycle.
  - Counter width is clog2(DEBOUNCE_MS+1); it saturates and never wraps.
- btns = stable, registered.
- press[i] = stable rising edge, asserted one cycle after stable rises.
- Command decode:
  - press[0..3] selects cmd 00/01/10/11 respectively.
  - Registered: cmd and cmd_valid update the cycle after press.
  - Simultaneous presses in the same cycle: lowest index wins. Exactly one cmd_valid pulse is generated.
  - Re-pressing the current command still pulses cmd_valid; cmd is unchanged.
  - Releases never change cmd.
  - Buttons 4..8 never affect cmd. They only appear on btns.
- Latency: raw edge to stable is 2 sync cycles plus between DEBOUNCE_MS and DEBOUNCE_MS+1 tick periods. Stable to cmd_valid is 2 cycles.
- Reset mid-debounce: the partial count is discarded, and cmd returns to OFF.

Optional Feature:
- CMD_LOCK_EN defined:
  - press[8] toggles cmd_locked.
  - While cmd_locked=1, press[0..3] is ignored: no cmd change and no cmd_valid.
  - If press[8] and a press[0..3] occur in the same cycle, the command is evaluated against the pre-toggle lock state.
- CMD_LOCK_EN undefined: cmd_locked is tied 0, and button 8 is a plain btns bit.

Decomposition:
- Package btn_pkg holds:
  - cmd encodings: CMD_OFF=2'b00, CMD_ON=2'b01, CMD_BLINK_SLOW=2'b10, CMD_BLINK_FAST=2'b11.
  - NUM_BTNS=9.
  - CMD_BTN_LO=0, CMD_BTN_HI=3, LOCK_BTN=8.
- Sub-module btn_debounce: one instance per button via generate, containing the synchroniser, counter and stable flop. It takes the shared tick. The prescaler and command logic stay in btn_cmd_ctrl.

Test Plan (sim params CLK_HZ=8000 giving tick every 8 cycles, DEBOUNCE_MS=4, BTN_ACTIVE_LOW=1):
- Reset release, all btns_raw=9'h1FF held for 100 cycles -> btns=0, cmd=00, cmd_valid never high.
- btns_raw[2] driven low and held -> btns[2] rises 2 cycles + 32..40 cycles after the edge. cmd=10 and cmd_valid pulses exactly once, 2 cycles after btns[2] rises.
- btns_raw[1] bounces: low 20 cycles, high 3, low held -> no btns[1] rise before 32 cycles after the final low edge. Exactly one cmd_valid, with cmd=01.
- btns_raw[3] and btns_raw[0] low in the same cycle -> one cmd_valid, cmd=00. Release of both leaves cmd unchanged.
- rst_n pulled low mid-count (16 cycles after a btns_raw[1] press) -> outputs clear immediately. After release the held button re-debounces in the full 32..40 cycles and sets cmd=01.
- CMD_LOCK_EN: press btn 8, then btn 3 -> cmd_locked=1, cmd unchanged, no cmd_valid. Press btn 8 again, then btn 3 -> cmd_locked=0, cmd=11, one cmd_valid.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the button front end: command encodings and button roles.
package btn_pkg;

  localparam int NUM_BTNS   = 9;
  localparam int CMD_BTN_LO = 0;
  localparam int CMD_BTN_HI = 3;
  localparam int LOCK_BTN   = 8;

  typedef enum logic [1:0] {
    CMD_OFF        = 2'b00,
    CMD_ON         = 2'b01,
    CMD_BLINK_SLOW = 2'b10,
    CMD_BLINK_FAST = 2'b11
  } cmd_e;

  // Lowest pressed command button wins; hit=0 when none is pressed.
  function automatic void pick_cmd(input logic [CMD_BTN_HI:CMD_BTN_LO] press,
                                   output logic hit, output cmd_e sel);
    hit = 1'b0;
    sel = CMD_OFF;
    for (int i = CMD_BTN_HI; i >= CMD_BTN_LO; i--) begin
      if (press[i]) begin
        hit = 1'b1;
        sel = cmd_e'(i[1:0]);
      end
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, polarity fix, tick-counted debounce, stable level.
module btn_debounce #(
  parameter int DEBOUNCE_MS    = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic stable
);

  localparam int            CW       = $clog2(DEBOUNCE_MS + 1);
  localparam logic          RELEASED = BTN_ACTIVE_LOW;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_MS);

  logic [1:0]    sync_ff;
  logic          sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_ff <= {2{RELEASED}};
    else        sync_ff <= {sync_ff[0], raw};
  end

  assign sync = sync_ff[1] ^ RELEASED;

  // Flip only on the tick that finds the counter already at CNT_MAX, so the
  // disagreement must survive DEBOUNCE_MS full tick periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync == stable) begin
      cnt <= '0;
    end else if (tick) begin
      if (cnt == CNT_MAX) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Button front end for led_handler: 1 kHz prescaler, per-button debounce, command latch.
// Optional command lock on button 8 is enabled by defining CMD_LOCK_EN.
module btn_cmd_ctrl
  import btn_pkg::*;
#(
  parameter int CLK_HZ         = 12000000,
  parameter int DEBOUNCE_MS    = 10,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                hwclk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btns_raw,
  output logic [NUM_BTNS-1:0] btns,
  output logic [1:0]          cmd,
  output logic                cmd_valid,
  output logic                cmd_locked
);

  localparam int TICK_DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]                presc;
  logic                         tick;
  logic [NUM_BTNS-1:0]          stable;
  logic [CMD_BTN_HI:CMD_BTN_LO] cmd_stable_d, cmd_press;
  logic                         cmd_hit, cmd_accept, lock_q, cmd_valid_q;
  cmd_e                         cmd_sel, cmd_q;

  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_MS   (DEBOUNCE_MS),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_db (
      .clk   (hwclk),
      .rst_n (rst_n),
      .tick  (tick),
      .raw   (btns_raw[g]),
      .stable(stable[g])
    );
  end

  assign btns = stable;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_stable_d <= '0;
      cmd_press    <= '0;
    end else begin
      cmd_stable_d <= stable[CMD_BTN_HI:CMD_BTN_LO];
      cmd_press    <= stable[CMD_BTN_HI:CMD_BTN_LO] & ~cmd_stable_d;
    end
  end

  always_comb begin
    pick_cmd(cmd_press, cmd_hit, cmd_sel);
  end

`ifdef CMD_LOCK_EN
  logic lock_stable_d, lock_press;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_stable_d <= 1'b0;
      lock_press    <= 1'b0;
      lock_q        <= 1'b0;
    end else begin
      lock_stable_d <= stable[LOCK_BTN];
      lock_press    <= stable[LOCK_BTN] & ~lock_stable_d;
      if (lock_press) lock_q <= ~lock_q;
    end
  end
`else
  assign lock_q = 1'b0;
`endif

  // Acceptance uses the lock value before any toggle in the same cycle.
  assign cmd_accept = cmd_hit & ~lock_q;

  // cmd_valid is a one-cycle strobe with no backpressure; cmd holds between strobes.
  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= CMD_OFF;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_valid_q <= cmd_accept;
      if (cmd_accept) cmd_q <= cmd_sel;
    end
  end

  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_locked = lock_q;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Self-checking bench for btn_cmd_ctrl: table vectors, multi-cycle corner sequences,
// and randomized presses/glitches against a press-level reference model.
module tb_btn_cmd_ctrl;
  import btn_pkg::*;

  logic       hwclk    = 1'b0;
  logic       rst_n    = 1'b0;
  logic [8:0] btns_raw = 9'h1FF;
  logic [8:0] btns;
  logic [1:0] cmd;
  logic       cmd_valid;
  logic       cmd_locked;

  int n_checks  = 0;
  int n_fail    = 0;
  int valid_cnt = 0;

  always #5 hwclk = ~hwclk;

  btn_cmd_ctrl #(
    .CLK_HZ        (8000),
    .DEBOUNCE_MS   (4),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .hwclk     (hwclk),
    .rst_n     (rst_n),
    .btns_raw  (btns_raw),
    .btns      (btns),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_locked(cmd_locked)
  );

  always @(negedge hwclk) begin
    if (rst_n && cmd_valid === 1'b1) valid_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [8:0] mask;
    int         hold;
    logic [8:0] exp_btns;
    logic [1:0] exp_cmd;
    int         exp_valid;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic drive(input logic [8:0] mask);
    btns_raw = ~mask;
  endtask

  // Posedges from now until btns[idx] reads 1 at the following negedge.
  task automatic wait_rise(input int idx, input int limit, output int n);
    n = 0;
    do begin
      @(posedge hwclk);
      n++;
      @(negedge hwclk);
    end while (btns[idx] !== 1'b1 && n < limit);
  endtask

  logic [1:0] m_cmd;
  logic       m_lock;
  int         n, m, v0;

  initial begin
    for (int i = 0; i < 9; i++) vecs[i] = '{9'h000, 50, 9'h000, 2'b00, 0};
    vecs[0] = '{9'h004, 50, 9'h004, CMD_BLINK_SLOW, 1};
    vecs[1] = '{9'h002, 50, 9'h002, CMD_ON,         1};
    vecs[2] = '{9'h009, 50, 9'h009, CMD_OFF,        1};
    vecs[3] = '{9'h002, 10, 9'h000, CMD_OFF,        0};
    vecs[4] = '{9'h0F0, 50, 9'h0F0, CMD_OFF,        0};
    vecs[5] = '{9'h008, 50, 9'h008, CMD_BLINK_FAST, 1};
    vecs[6] = '{9'h008, 50, 9'h008, CMD_BLINK_FAST, 1};
    vecs[7] = '{9'h00C, 50, 9'h00C, CMD_BLINK_SLOW, 1};
    vecs[8] = '{9'h030, 50, 9'h030, CMD_BLINK_SLOW, 0};

    // Reset state and quiet idle.
    cycles(3);
    check("rst_btns", btns, 0);
    check("rst_cmd", cmd, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_locked", cmd_locked, 0);
    rst_n = 1'b1;
    cycles(100);
    check("idle_btns", btns, 0);
    check("idle_cmd", cmd, 0);
    check("idle_valid_cnt", valid_cnt, 0);

    // Single press latency on button 2.
    v0 = valid_cnt;
    drive(9'h004);
    wait_rise(2, 60, n);
    check("btn2_rise_window", (n >= 34 && n <= 42), 1);
    m = 0;
    do begin
      @(posedge hwclk);
      m++;
      @(negedge hwclk);
    end while (cmd_valid !== 1'b1 && m < 10);
    check("btn2_valid_delay", m, 2);
    cycles(20);
    check("btn2_cmd", cmd, 2'b10);
    check("btn2_valid_once", valid_cnt - v0, 1);
    drive(9'h000);
    cycles(60);
    check("btn2_release_btns", btns, 0);
    check("btn2_release_cmd", cmd, 2'b10);

    // Bouncing button 1.
    v0 = valid_cnt;
    drive(9'h002);
    cycles(20);
    drive(9'h000);
    cycles(3);
    drive(9'h002);
    wait_rise(1, 60, n);
    check("bounce_rise_window", (n >= 32 && n <= 42), 1);
    cycles(5);
    check("bounce_cmd", cmd, 2'b01);
    check("bounce_valid_once", valid_cnt - v0, 1);
    drive(9'h000);
    cycles(60);

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      v0 = valid_cnt;
      drive(vecs[i].mask);
      cycles(vecs[i].hold);
      check($sformatf("vec%0d_btns", i), btns, vecs[i].exp_btns);
      drive(9'h000);
      cycles(50);
      check($sformatf("vec%0d_cmd", i), cmd, vecs[i].exp_cmd);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_released", i), btns, 0);
    end

    // Reset in the middle of a debounce count.
    drive(9'h002);
    cycles(16);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_btns", btns, 0);
    check("midrst_cmd", cmd, 0);
    check("midrst_valid", cmd_valid, 0);
    cycles(3);
    v0 = valid_cnt;
    rst_n = 1'b1;
    wait_rise(1, 60, n);
    check("midrst_rise_window", (n >= 34 && n <= 42), 1);
    cycles(3);
    check("midrst_cmd_after", cmd, 2'b01);
    check("midrst_valid_once", valid_cnt - v0, 1);
    drive(9'h000);
    cycles(60);

`ifdef CMD_LOCK_EN
    v0 = valid_cnt;
    drive(9'h100); cycles(50); drive(9'h000); cycles(50);
    check("lock_on", cmd_locked, 1);
    drive(9'h008); cycles(50); drive(9'h000); cycles(50);
    check("lock_cmd_held", cmd, 2'b01);
    check("lock_no_valid", valid_cnt - v0, 0);
    drive(9'h100); cycles(50); drive(9'h000); cycles(50);
    check("lock_off", cmd_locked, 0);
    drive(9'h008); cycles(50); drive(9'h000); cycles(50);
    check("unlock_cmd", cmd, 2'b11);
    check("unlock_valid", valid_cnt - v0, 1);
    m_lock = 1'b0;
`else
    check("nolock_tied", cmd_locked, 0);
    m_lock = 1'b0;
`endif

    // Randomized presses and glitches against a press-level model.
    m_cmd = cmd;
    for (int e = 0; e < 25; e++) begin
      int kind, b1, dur, exp_v;
      logic [8:0] mask;
      v0    = valid_cnt;
      kind  = $urandom_range(0, 3);
      b1    = $urandom_range(0, 8);
      mask  = 9'h000;
      mask[b1] = 1'b1;
      exp_v = 0;
      if (kind == 0) begin
        dur = $urandom_range(1, 20);
        drive(mask);
        cycles(dur);
        drive(9'h000);
        cycles(50);
        check($sformatf("rnd%0d_glitch_btns", e), btns, 0);
      end else begin
        if ($urandom_range(0, 1) == 1) mask[$urandom_range(0, 8)] = 1'b1;
        drive(mask);
        cycles(50);
        check($sformatf("rnd%0d_btns", e), btns, mask);
        drive(9'h000);
        cycles(50);
        for (int i = 3; i >= 0; i--) begin
          if (mask[i] && !m_lock) begin
            m_cmd = 2'(i);
            exp_v = 1;
          end
        end
`ifdef CMD_LOCK_EN
        if (mask[8]) m_lock = ~m_lock;
`endif
      end
      check($sformatf("rnd%0d_cmd", e), cmd, m_cmd);
      check($sformatf("rnd%0d_valid", e), valid_cnt - v0, exp_v);
      check($sformatf("rnd%0d_locked", e), cmd_locked, m_lock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
